// File: rtl/ram_arbiter.sv
// Two-requester arbiter and sequencer for a single-port, asynchronous-read RAM.
// Requester 0 is the CPU data port and requester 1 is the loader/debug port.
// One request is accepted at a time. The RAM is driven for exactly one access
// cycle, and then a one-cycle response pulse goes back to the requester that won.
//
//  state   | meaning
//  --------+-----------------------------------------------------------------
//  IDLE    | arbitrating; req_ready goes combinationally to the winner
//  ACCESS  | RAM driven from latched request; read data captured at exit edge
//  RESPOND | rsp_valid pulsed to the latched owner; then back to IDLE
module ram_arbiter #(
    parameter int addr_bits = 16,
    parameter int data_bits = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_write,
    input  logic [2*addr_bits-1:0] req_addr,
    input  logic [2*data_bits-1:0] req_wdata,
    output logic [1:0]             rsp_valid,
    output logic [data_bits-1:0]   rsp_rdata,
    output logic                   ram_write_enable,
    output logic [addr_bits-1:0]   ram_address,
    output logic [data_bits-1:0]   ram_data_in,
    input  logic [data_bits-1:0]   ram_data_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                 state;
    logic                   last_grant;
    logic                   owner;
    logic                   op_write;
    logic [addr_bits-1:0]   lat_addr;
    logic [data_bits-1:0]   lat_wdata;

    logic                   grant_any;
    logic                   grant_id;
    logic                   sel_write;
    logic [addr_bits-1:0]   sel_addr;
    logic [data_bits-1:0]   sel_wdata;

    // Round-robin winner: a lone requester wins, on contention the one not served last.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        case (req_valid)
            2'b01: begin
                grant_any = 1'b1;
                grant_id  = 1'b0;
            end
            2'b10: begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
            2'b11: begin
                grant_any = 1'b1;
                grant_id  = ~last_grant;
            end
            default: begin
                grant_any = 1'b0;
                grant_id  = 1'b0;
            end
        endcase
    end

    // Select the winning requester's payload so it can be latched at the transfer edge.
    always_comb begin
        sel_write = grant_id ? req_write[1] : req_write[0];
        sel_addr  = grant_id ? req_addr[addr_bits +: addr_bits] : req_addr[0 +: addr_bits];
        sel_wdata = grant_id ? req_wdata[data_bits +: data_bits] : req_wdata[0 +: data_bits];
    end

    // Accept is offered only while idle, and only to the current winner.
    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE && grant_any) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // The latched request drives the RAM directly, so address and data hold between accesses.
    assign ram_address = lat_addr;
    assign ram_data_in = lat_wdata;

    // Sequencer: latch on transfer, one RAM access cycle, one response cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            last_grant       <= 1'b1;
            owner            <= 1'b0;
            op_write         <= 1'b0;
            lat_addr         <= '0;
            lat_wdata        <= '0;
            ram_write_enable <= 1'b0;
            rsp_valid        <= 2'b00;
            rsp_rdata        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid        <= 2'b00;
                    ram_write_enable <= 1'b0;
                    if (grant_any) begin
                        owner            <= grant_id;
                        op_write         <= sel_write;
                        lat_addr         <= sel_addr;
                        lat_wdata        <= sel_wdata;
                        last_grant       <= grant_id;
                        // Registered strobe: high for the whole ACCESS cycle, never glitches.
                        ram_write_enable <= sel_write;
                        state            <= ACCESS;
                    end
                end
                ACCESS: begin
                    ram_write_enable <= 1'b0;
                    if (!op_write) begin
                        rsp_rdata <= ram_data_out;
                    end
                    rsp_valid <= owner ? 2'b10 : 2'b01;
                    state     <= RESPOND;
                end
                RESPOND: begin
                    rsp_valid <= 2'b00;
                    state     <= IDLE;
                end
                default: begin
                    rsp_valid        <= 2'b00;
                    ram_write_enable <= 1'b0;
                    state            <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter. It includes a behavioural RAM and a transaction-level
// reference model that tracks the cycles elapsed since the last accept.
module tb_ram_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [1:0]      req_valid = 2'b00;
    logic [1:0]      req_ready;
    logic [1:0]      req_write = 2'b00;
    logic [2*AW-1:0] req_addr = '0;
    logic [2*DW-1:0] req_wdata = '0;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            ram_write_enable;
    logic [AW-1:0]   ram_address;
    logic [DW-1:0]   ram_data_in;
    logic [DW-1:0]   ram_data_out;

    always #5 clk = ~clk;

    ram_arbiter #(.addr_bits(AW), .data_bits(DW)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .ram_write_enable (ram_write_enable),
        .ram_address      (ram_address),
        .ram_data_in      (ram_data_in),
        .ram_data_out     (ram_data_out)
    );

    // Behavioural RAM: combinational read, write on the rising edge.
    logic [DW-1:0] mem     [0:65535];
    logic [DW-1:0] ref_mem [0:65535];
    assign ram_data_out = mem[ram_address];
    always @(posedge clk) if (ram_write_enable) mem[ram_address] <= ram_data_in;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state (transaction level)
    int            k = 2;            // cycles since accept: 0 access, 1 respond, >=2 idle
    bit            m_owner = 1'b0;
    bit            m_write = 1'b0;
    bit            m_last = 1'b1;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;
    bit            pend = 1'b0;
    bit            p_owner, p_write;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;

    // Observation records
    int            cyc = 0;
    int            g_owner[$];
    int            g_cyc[$];
    int            r_owner[$];
    logic [DW-1:0] r_data[$];
    int            we_cnt = 0;
    logic [AW-1:0] we_addr = '0;
    logic [DW-1:0] we_data = '0;

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        logic [1:0] er, erv, acc;
        logic       ewe;
        int         idx;
        if (reset) begin
            k = 2; m_last = 1'b1; m_owner = 1'b0; m_write = 1'b0;
            m_addr = '0; m_wdata = '0; m_rdata = '0; pend = 1'b0;
            chk("rst_ready", 32'(req_ready), 32'(0));
            chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
            chk("rst_we", 32'(ram_write_enable), 32'(0));
            chk("rst_rdata", 32'(rsp_rdata), 32'(0));
            chk("rst_addr", 32'(ram_address), 32'(0));
        end else begin
            er = 2'b00;
            if (k >= 2) begin
                if (req_valid == 2'b01) er = 2'b01;
                else if (req_valid == 2'b10) er = 2'b10;
                else if (req_valid == 2'b11) er = m_last ? 2'b01 : 2'b10;
            end
            ewe = (k == 0) && m_write;
            erv = (k == 1) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
            chk("req_ready", 32'(req_ready), 32'(er));
            chk("ram_we", 32'(ram_write_enable), 32'(ewe));
            chk("rsp_valid", 32'(rsp_valid), 32'(erv));
            chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
            chk("ram_address", 32'(ram_address), 32'(m_addr));
            chk("ram_data_in", 32'(ram_data_in), 32'(m_wdata));
            chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'(1));

            if (ram_write_enable) begin
                we_cnt++;
                we_addr = ram_address;
                we_data = ram_data_in;
            end
            if (rsp_valid != 2'b00) begin
                r_owner.push_back(rsp_valid[1] ? 1 : 0);
                r_data.push_back(rsp_rdata);
            end
            acc = req_ready & req_valid;
            if (acc != 2'b00) begin
                g_owner.push_back(acc[1] ? 1 : 0);
                g_cyc.push_back(cyc);
            end

            pend = (er & req_valid) != 2'b00;
            if (pend) begin
                p_owner = er[1];
                idx     = p_owner ? 1 : 0;
                p_write = req_write[idx];
                p_addr  = req_addr[idx*AW +: AW];
                p_wdata = req_wdata[idx*DW +: DW];
            end
        end
    end

    // Advance the model at each rising edge.
    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            if (k == 0) begin
                if (m_write) ref_mem[m_addr] = m_wdata;
                else m_rdata = ref_mem[m_addr];
            end
            if (k < 2) k++;
            if (pend) begin
                k = 0;
                m_owner = p_owner; m_write = p_write;
                m_addr = p_addr; m_wdata = p_wdata;
                m_last = p_owner;
                pend = 1'b0;
            end
        end
    end

    task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[i]          = wr;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_valid[i]          = 1'b1;
    endtask

    task automatic wait_accept(input int i, output bit ok);
        bit rdy;
        ok = 1'b0;
        for (int n = 0; n < 30 && !ok; n++) begin
            @(negedge clk);
            rdy = req_ready[i];
            @(posedge clk);
            #1;
            if (rdy) ok = 1'b1;
        end
        req_valid[i] = 1'b0;
        chk("accept", 32'(ok), 32'(1));
    endtask

    task automatic xact(input int i, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output logic [DW-1:0] rd);
        bit ok;
        int got;
        rd = '0;
        set_req(i, wr, a, d);
        wait_accept(i, ok);
        if (!ok) return;
        got = 0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (rsp_valid[i]) begin
                got = n;
                rd  = rsp_rdata;
                break;
            end
        end
        chk("rsp_latency", 32'(got), 32'(2));
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_grants(input int want);
        for (int n = 0; n < 60 && g_owner.size() < want; n++) @(posedge clk);
        #1;
        req_valid = 2'b00;
        chk("grant_count", 32'(g_owner.size()), 32'(want));
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] rd;
        int            we0, cnt1;
        bit            ok;
        for (int a = 0; a < 65536; a++) begin
            mem[a]     = '0;
            ref_mem[a] = '0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_rdata_literal", 32'(rsp_rdata), 32'(0));

        // Single read after a preload through requester 1
        xact(1, 1'b1, 16'h0010, 8'hA5, rd);
        we0 = we_cnt;
        xact(0, 1'b0, 16'h0010, 8'h00, rd);
        chk("read_a5", 32'(rd), 32'h A5);
        chk("read_no_we", 32'(we_cnt - we0), 32'(0));

        // Single write to the top address, then read back
        we0 = we_cnt;
        xact(1, 1'b1, 16'hFFFF, 8'h3C, rd);
        chk("wr_we_cycles", 32'(we_cnt - we0), 32'(1));
        chk("wr_addr", 32'(we_addr), 32'h FFFF);
        chk("wr_data", 32'(we_data), 32'h 3C);
        xact(1, 1'b0, 16'hFFFF, 8'h00, rd);
        chk("read_3c", 32'(rd), 32'h 3C);

        // Contention: requester 1 was served last, so order starts at 0
        g_owner.delete(); g_cyc.delete(); r_owner.delete(); r_data.delete();
        set_req(0, 1'b0, 16'h0010, 8'h00);
        set_req(1, 1'b0, 16'hFFFF, 8'h00);
        run_until_grants(6);
        for (int i = 0; i < 6 && i < g_owner.size(); i++) begin
            chk("grant_order", 32'(g_owner[i]), 32'(i % 2));
            if (i > 0) chk("grant_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'(3));
        end
        chk("contention_rsp_count", 32'(r_data.size()), 32'(6));
        for (int i = 0; i < 6 && i < r_data.size(); i++) begin
            chk("contention_rdata", 32'(r_data[i]), (i % 2 == 0) ? 32'h A5 : 32'h 3C);
        end

        // Back-to-back reads from requester 0
        for (int a = 0; a < 4; a++) xact(1, 1'b1, 16'(a), 8'(a + 1), rd);
        g_owner.delete(); g_cyc.delete();
        for (int a = 0; a < 4; a++) begin
            xact(0, 1'b0, 16'(a), 8'h00, rd);
            chk("b2b_rdata", 32'(rd), 32'(a + 1));
        end
        cnt1 = 0;
        foreach (g_owner[i]) if (g_owner[i] == 1) cnt1++;
        chk("b2b_no_req1", 32'(cnt1), 32'(0));

        // Idle stability
        we0 = we_cnt;
        repeat (20) @(posedge clk);
        #1;
        chk("idle_rdata", 32'(rsp_rdata), 32'h 04);
        chk("idle_no_we", 32'(we_cnt - we0), 32'(0));

        // Randomized traffic on a small address window
        g_owner.delete();
        for (int n = 0; n < 500; n++) begin
            @(posedge clk);
            #1;
            req_valid = 2'($urandom);
            req_write = 2'($urandom);
            for (int i = 0; i < 2; i++) begin
                req_addr[i*AW +: AW]  = 16'($urandom_range(0, 15));
                req_wdata[i*DW +: DW] = 8'($urandom);
            end
        end
        req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;
        chk("random_activity", 32'(g_owner.size() > 50), 32'(1));

        // Reset in the middle of a write ACCESS cycle
        xact(1, 1'b1, 16'h0020, 8'h11, rd);
        set_req(0, 1'b1, 16'h0020, 8'h77);
        wait_accept(0, ok);
        #2;
        chk("pre_reset_we", 32'(ram_write_enable), 32'(1));
        reset = 1'b1;
        #1;
        chk("reset_async_we", 32'(ram_write_enable), 32'(0));
        chk("reset_async_rsp", 32'(rsp_valid), 32'(0));
        r_owner.delete(); r_data.delete(); g_owner.delete(); g_cyc.delete();
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        set_req(0, 1'b0, 16'h0020, 8'h00);
        set_req(1, 1'b0, 16'h0010, 8'h00);
        run_until_grants(2);
        if (g_owner.size() >= 2) begin
            chk("post_reset_first_grant", 32'(g_owner[0]), 32'(0));
            chk("post_reset_second_grant", 32'(g_owner[1]), 32'(1));
        end
        chk("post_reset_rsp_count", 32'(r_data.size()), 32'(2));
        if (r_data.size() >= 2) begin
            chk("post_reset_rdata0", 32'(r_data[0]), 32'h 11);
            chk("post_reset_owner0", 32'(r_owner[0]), 32'(0));
            chk("post_reset_rdata1", 32'(r_data[1]), 32'h A5);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
